axi_lite_dram_slave: RTL and testbench

AXI_LITE_DRAM_SLAVE -- requirements
Module: axi_lite_dram_slave

---
 rtl/axi_lite_dram_slave_pkg.sv | 24 ++
 rtl/axi_lite_dram_slave_if.sv | 31 +++
 rtl/axi_lite_dram_slave_mem_array.sv | 22 ++
 rtl/axi_lite_dram_slave.sv | 201 ++++++++++++++++++++
 tb/tb_axi_lite_dram_slave.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_dram_slave_pkg.sv
// Shared types and constants for the AXI-Lite DRAM slave: FSM state encoding,
// AXI response codes, default base address and the latency LFSR step.
package usertype;

   typedef enum logic [2:0] {
      IDLE,
      RA,
      RWAIT,
      RD,
      WA,
      WD,
      WB
   } state_dram;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [16:0] DRAM_BASE   = 17'h10000;

   // Maximal-length 4-bit LFSR (x^4 + x^3 + 1); never reaches zero from a non-zero seed.
   function automatic logic [3:0] lfsr4_next(input logic [3:0] s);
      return {s[2:0], s[3] ^ s[2]};
   endfunction

endpackage

// File: rtl/axi_lite_dram_slave_if.sv
// AXI-Lite bus bundle between a master and the DRAM slave; one modport per side.
interface axi_lite_dram_slave_if #(
   parameter int ADDR_W = 17
);
   logic [ADDR_W-1:0] AR_ADDR;
   logic              AR_VALID;
   logic              AR_READY;
   logic [31:0]       R_DATA;
   logic [1:0]        R_RESP;
   logic              R_VALID;
   logic              R_READY;
   logic [ADDR_W-1:0] AW_ADDR;
   logic              AW_VALID;
   logic              AW_READY;
   logic [31:0]       W_DATA;
   logic              W_VALID;
   logic              W_READY;
   logic [1:0]        B_RESP;
   logic              B_VALID;
   logic              B_READY;

   modport master (
      output AR_ADDR, AR_VALID, R_READY, AW_ADDR, AW_VALID, W_DATA, W_VALID, B_READY,
      input  AR_READY, R_DATA, R_RESP, R_VALID, AW_READY, W_READY, B_RESP, B_VALID
   );

   modport slave (
      input  AR_ADDR, AR_VALID, R_READY, AW_ADDR, AW_VALID, W_DATA, W_VALID, B_READY,
      output AR_READY, R_DATA, R_RESP, R_VALID, AW_READY, W_READY, B_RESP, B_VALID
   );
endinterface

// File: rtl/axi_lite_dram_slave_mem_array.sv
// Word storage for the DRAM slave: synchronous write, combinational read, contents never reset.
module dram_mem_array #(
   parameter int DEPTH = 256,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [31:0]      wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [31:0]      rdata
);
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/axi_lite_dram_slave.sv
// AXI-Lite slave in front of a small word memory, one transaction at a time, all outputs registered.
// Optional DRAM_RAND_LAT_EN adds LFSR-driven extra read latency and write-data entry delay.
module axi_lite_dram_slave
   import usertype::*;
#(
   parameter int                ADDR_W = 17,
   parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(DRAM_BASE),
   parameter int                DEPTH  = 256,
   parameter int                RD_LAT = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   axi_lite_dram_slave_if.slave  bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = 5;
   localparam logic [ADDR_W:0] LAST = {1'b0, BASE} + (ADDR_W+1)'(4 * (DEPTH - 1));

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} <= LAST) && (a[1:0] == 2'b00);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - BASE;
      return IDX_W'(off >> 2);
   endfunction

   state_dram          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ar_ready_q, ar_ready_d, aw_ready_q, aw_ready_d, w_ready_q, w_ready_d;
   logic               r_valid_q, r_valid_d, b_valid_q, b_valid_d;
   logic [31:0]        r_data_q, r_data_d;
   logic [1:0]         r_resp_q, r_resp_d, b_resp_q, b_resp_d;
   logic [IDX_W-1:0]   widx_q, widx_d;
   logic               wlegal_q, wlegal_d;
   logic [CNT_W-1:0]   rd_wait;
   logic [31:0]        mem_rdata;
   logic               mem_we;

`ifdef DRAM_RAND_LAT_EN
   logic [3:0] lfsr_q;

   // The LFSR steps once per read-address handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_q <= 4'h1;
      end else if (state_q == RA && bus.AR_VALID) begin
         lfsr_q <= lfsr4_next(lfsr_q);
      end
   end

   assign rd_wait = CNT_W'(RD_LAT - 1) + CNT_W'(lfsr_q[2:0]);
`else
   assign rd_wait = CNT_W'(RD_LAT - 1);
`endif

   // Only a completed W handshake to a legal address touches memory.
   assign mem_we = rst_n && (state_q == WD) && w_ready_q && bus.W_VALID && wlegal_q;

   dram_mem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (widx_q),
      .wdata (bus.W_DATA),
      .raddr (addr_idx(bus.AR_ADDR)),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ar_ready_q <= 1'b0;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         r_valid_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         r_data_q   <= '0;
         r_resp_q   <= RESP_OKAY;
         b_resp_q   <= RESP_OKAY;
         widx_q     <= '0;
         wlegal_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ar_ready_q <= ar_ready_d;
         aw_ready_q <= aw_ready_d;
         w_ready_q  <= w_ready_d;
         r_valid_q  <= r_valid_d;
         b_valid_q  <= b_valid_d;
         r_data_q   <= r_data_d;
         r_resp_q   <= r_resp_d;
         b_resp_q   <= b_resp_d;
         widx_q     <= widx_d;
         wlegal_q   <= wlegal_d;
      end
   end

   // Next-state logic also computes the next value of every registered output.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ar_ready_d = 1'b0;
      aw_ready_d = 1'b0;
      w_ready_d  = w_ready_q;
      r_valid_d  = r_valid_q;
      b_valid_d  = b_valid_q;
      r_data_d   = r_data_q;
      r_resp_d   = r_resp_q;
      b_resp_d   = b_resp_q;
      widx_d     = widx_q;
      wlegal_d   = wlegal_q;
      case (state_q)
         IDLE: begin
            if (bus.AR_VALID) begin
               state_d    = RA;
               ar_ready_d = 1'b1;
            end else if (bus.AW_VALID) begin
               state_d    = WA;
               aw_ready_d = 1'b1;
            end
         end
         RA: begin
            r_data_d = addr_ok(bus.AR_ADDR) ? mem_rdata : 32'h0;
            r_resp_d = addr_ok(bus.AR_ADDR) ? RESP_OKAY : RESP_SLVERR;
            if (rd_wait == '0) begin
               state_d   = RD;
               r_valid_d = 1'b1;
            end else begin
               state_d = RWAIT;
               cnt_d   = rd_wait;
            end
         end
         RWAIT: begin
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d     = '0;
               state_d   = RD;
               r_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RD: begin
            if (bus.R_READY) begin
               state_d   = IDLE;
               r_valid_d = 1'b0;
            end
         end
         WA: begin
`ifdef DRAM_RAND_LAT_EN
            if (aw_ready_q) begin
               widx_d   = addr_idx(bus.AW_ADDR);
               wlegal_d = addr_ok(bus.AW_ADDR);
               if (lfsr_q[1:0] == 2'b00) begin
                  state_d   = WD;
                  w_ready_d = 1'b1;
               end else begin
                  cnt_d = CNT_W'(lfsr_q[1:0]);
               end
            end else if (cnt_q <= CNT_W'(1)) begin
               cnt_d     = '0;
               state_d   = WD;
               w_ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
`else
            widx_d    = addr_idx(bus.AW_ADDR);
            wlegal_d  = addr_ok(bus.AW_ADDR);
            state_d   = WD;
            w_ready_d = 1'b1;
`endif
         end
         WD: begin
            if (bus.W_VALID) begin
               state_d   = WB;
               w_ready_d = 1'b0;
               b_valid_d = 1'b1;
               b_resp_d  = wlegal_q ? RESP_OKAY : RESP_SLVERR;
            end
         end
         WB: begin
            if (bus.B_READY) begin
               state_d   = IDLE;
               b_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.AR_READY = ar_ready_q;
   assign bus.AW_READY = aw_ready_q;
   assign bus.W_READY  = w_ready_q;
   assign bus.R_VALID  = r_valid_q;
   assign bus.R_DATA   = r_data_q;
   assign bus.R_RESP   = r_resp_q;
   assign bus.B_VALID  = b_valid_q;
   assign bus.B_RESP   = b_resp_q;
endmodule

// File: tb/tb_axi_lite_dram_slave.sv
// Self-checking bench for axi_lite_dram_slave: directed transactions against a
// word-level memory model, with a per-cycle compare process on the R and B channels.
module tb_axi_lite_dram_slave;
   localparam int          RD_LAT = 2;
   localparam int unsigned MBASE  = 32'h10000;
   localparam int unsigned MDEPTH = 256;

   typedef struct { logic [31:0] data; logic [1:0] resp; } exp_t;
   typedef struct { bit isWrite; logic [16:0] addr; logic [31:0] data; int hold; } vec_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   exp_t        rq[$];
   exp_t        bq[$];
   logic [31:0] modelMem [int];
   int          lastArCyc = 0, lastAwCyc = 0, lastRhsCyc = 0;
   bit          prevAr = 0, prevRv = 0, rdBusy = 0;

   axi_lite_dram_slave_if #(.ADDR_W(17)) bus ();

   axi_lite_dram_slave #(
      .ADDR_W(17), .BASE(17'h10000), .DEPTH(256), .RD_LAT(RD_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit modelLegal(input logic [16:0] a);
      int unsigned ua;
      ua = 32'(a);
      return (ua >= MBASE) && (ua <= MBASE + 4 * (MDEPTH - 1)) && (ua % 4 == 0);
   endfunction

   function automatic int modelIndex(input logic [16:0] a);
      return int'((32'(a) - MBASE) / 4);
   endfunction

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ar_ready"}, 32'(bus.AR_READY), 32'h0);
      checkOutput({tag, "_aw_ready"}, 32'(bus.AW_READY), 32'h0);
      checkOutput({tag, "_w_ready"},  32'(bus.W_READY),  32'h0);
      checkOutput({tag, "_r_valid"},  32'(bus.R_VALID),  32'h0);
      checkOutput({tag, "_b_valid"},  32'(bus.B_VALID),  32'h0);
      checkOutput({tag, "_r_data"},   bus.R_DATA,        32'h0);
      checkOutput({tag, "_r_resp"},   32'(bus.R_RESP),   32'h0);
      checkOutput({tag, "_b_resp"},   32'(bus.B_RESP),   32'h0);
   endtask

   task automatic doRead(input logic [16:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp);
      bit   ok;
      exp_t e;
      e.resp = modelLegal(addr) ? 2'b00 : 2'b10;
      e.data = modelLegal(addr) ? modelMem[modelIndex(addr)] : 32'h0;
      rq.push_back(e);
      bus.AR_ADDR  = addr;
      bus.AR_VALID = 1'b1;
      bus.R_READY  = (hold == 0);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (bus.AR_READY) begin ok = 1; break; end
      end
      if (!ok) timeoutFail("ar_ready_wait");
      tick();
      bus.AR_VALID = 1'b0;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (bus.R_VALID) begin ok = 1; break; end
         tick();
      end
      if (!ok) begin timeoutFail("r_valid_wait"); rq.delete(); end
      data = bus.R_DATA;
      resp = bus.R_RESP;
      for (int i = 0; i < hold; i++) begin
         checkOutput("r_hold_valid", 32'(bus.R_VALID), 32'h1);
         checkOutput("r_hold_data", bus.R_DATA, data);
         tick();
      end
      bus.R_READY = 1'b1;
      tick();
      bus.R_READY = 1'b0;
      checkOutput("r_valid_drop", 32'(bus.R_VALID), 32'h0);
   endtask

   task automatic doWrite(input logic [16:0] addr, input logic [31:0] data, input int wdelay,
                          output logic [1:0] resp);
      bit   ok;
      exp_t e;
      bus.AW_ADDR  = addr;
      bus.AW_VALID = 1'b1;
      bus.B_READY  = 1'b1;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (bus.AW_READY) begin ok = 1; break; end
      end
      if (!ok) timeoutFail("aw_ready_wait");
      tick();
      bus.AW_VALID = 1'b0;
      repeat (wdelay) tick();
      bus.W_DATA  = data;
      bus.W_VALID = 1'b1;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (bus.W_READY) begin ok = 1; break; end
         tick();
      end
      if (!ok) timeoutFail("w_ready_wait");
      tick();
      bus.W_VALID = 1'b0;
      if (modelLegal(addr)) modelMem[modelIndex(addr)] = data;
      e.data = 32'h0;
      e.resp = modelLegal(addr) ? 2'b00 : 2'b10;
      bq.push_back(e);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (bus.B_VALID) begin ok = 1; break; end
         tick();
      end
      if (!ok) begin timeoutFail("b_valid_wait"); bq.delete(); end
      resp = bus.B_RESP;
      tick();
      bus.B_READY = 1'b0;
      checkOutput("b_valid_drop", 32'(bus.B_VALID), 32'h0);
   endtask

   task automatic applyStimulus(input vec_t v);
      logic [31:0] d;
      logic [1:0]  r;
      if (v.isWrite) doWrite(v.addr, v.data, v.hold, r);
      else           doRead(v.addr, v.hold, d, r);
   endtask

   // Per-cycle checker: R/B payloads against the model queue, read latency,
   // single-cycle address ready and no write acceptance while a read is open.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prevAr = 0;
            prevRv = 0;
            rdBusy = 0;
         end else begin
            if (bus.AR_READY) begin
               checkOutput("ar_ready_single", 32'(prevAr), 32'h0);
               lastArCyc = cyc;
               rdBusy    = 1;
            end
            if (bus.AW_READY) begin
               checkOutput("aw_ready_while_read", 32'(rdBusy), 32'h0);
               lastAwCyc = cyc;
            end
            if (bus.R_VALID) begin
               if (rq.size() == 0) begin
                  checkOutput("r_valid_unexpected", 32'(bus.R_VALID), 32'h0);
               end else begin
                  if (!prevRv) checkOutput("r_latency", 32'(cyc - lastArCyc), 32'(RD_LAT));
                  checkOutput("r_data", bus.R_DATA, rq[0].data);
                  checkOutput("r_resp", 32'(bus.R_RESP), 32'(rq[0].resp));
                  if (bus.R_READY) begin
                     void'(rq.pop_front());
                     rdBusy     = 0;
                     lastRhsCyc = cyc;
                  end
               end
            end
            if (bus.B_VALID) begin
               if (bq.size() == 0) begin
                  checkOutput("b_valid_unexpected", 32'(bus.B_VALID), 32'h0);
               end else begin
                  checkOutput("b_resp", 32'(bus.B_RESP), 32'(bq[0].resp));
                  if (bus.B_READY) void'(bq.pop_front());
               end
            end
            prevAr = bus.AR_READY;
            prevRv = bus.R_VALID;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] d, d2;
      logic [1:0]  r, r2;
      bit          ok;
      vec_t        vecs[6];

      bus.AR_ADDR = '0; bus.AR_VALID = 0; bus.R_READY = 0;
      bus.AW_ADDR = '0; bus.AW_VALID = 0; bus.W_DATA = '0; bus.W_VALID = 0; bus.B_READY = 0;

      rst_n = 1'b0;
      repeat (3) tick();
      checkResetOutputs("reset");
      rst_n = 1'b1;
      tick();

      $display("[TB] last-word and word-0 write/read");
      doWrite(17'h10000, 32'h1111_1111, 0, r);
      checkOutput("w0_resp", 32'(r), 32'h0);
      doWrite(17'h103FC, 32'h2222_2222, 2, r);
      checkOutput("wlast_resp", 32'(r), 32'h0);
      doRead(17'h103FC, 0, d, r);
      checkOutput("rlast_data", d, 32'h2222_2222);
      doRead(17'h10000, 0, d, r);
      checkOutput("r0_data_after_last", d, 32'h1111_1111);

      $display("[TB] basic write then read");
      doWrite(17'h10004, 32'hDEAD_BEEF, 0, r);
      checkOutput("deadbeef_b_resp", 32'(r), 32'h0);
      doRead(17'h10004, 0, d, r);
      checkOutput("deadbeef_r_data", d, 32'hDEAD_BEEF);
      checkOutput("deadbeef_r_resp", 32'(r), 32'h0);

      $display("[TB] illegal accesses");
      doRead(17'h10400, 0, d, r);
      checkOutput("oor_r_data", d, 32'h0);
      checkOutput("oor_r_resp", 32'(r), 32'h2);
      doWrite(17'h10002, 32'hBAD0_BAD0, 0, r);
      checkOutput("unaligned_b_resp", 32'(r), 32'h2);
      doRead(17'h10000, 0, d, r);
      checkOutput("word0_unchanged", d, 32'h1111_1111);

      $display("[TB] R_READY held low");
      doRead(17'h10004, 5, d, r);
      checkOutput("hold_r_data", d, 32'hDEAD_BEEF);

      $display("[TB] simultaneous AR and AW");
      fork
         doRead(17'h10004, 0, d, r);
         doWrite(17'h1000C, 32'h1234_5678, 0, r2);
      join
      checkOutput("arb_read_data", d, 32'hDEAD_BEEF);
      checkOutput("arb_write_resp", 32'(r2), 32'h0);
      checkOutput("arb_aw_after_r", 32'(lastAwCyc > lastRhsCyc), 32'h1);
      doRead(17'h1000C, 0, d, r);
      checkOutput("arb_write_landed", d, 32'h1234_5678);

      $display("[TB] reset during write-data phase");
      doWrite(17'h10008, 32'hCAFE_F00D, 0, r);
      bus.AW_ADDR  = 17'h10008;
      bus.AW_VALID = 1'b1;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (bus.AW_READY) begin ok = 1; break; end
      end
      if (!ok) timeoutFail("mid_wd_aw_wait");
      tick();
      bus.AW_VALID = 1'b0;
      bus.W_DATA   = 32'h0BAD_F00D;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (bus.W_READY) begin ok = 1; break; end
         tick();
      end
      if (!ok) timeoutFail("mid_wd_w_ready_wait");
      rst_n = 1'b0;
      tick();
      checkResetOutputs("mid_wd");
      rst_n = 1'b1;
      tick();
      doRead(17'h10008, 0, d, r);
      checkOutput("mid_wd_old_data", d, 32'hCAFE_F00D);

      $display("[TB] directed vector table");
      vecs[0] = '{1'b1, 17'h10010, 32'hA5A5_A5A5, 1};
      vecs[1] = '{1'b0, 17'h10010, 32'h0, 2};
      vecs[2] = '{1'b0, 17'h0FFFC, 32'h0, 0};
      vecs[3] = '{1'b0, 17'h103FD, 32'h0, 0};
      vecs[4] = '{1'b1, 17'h10400, 32'hFFFF_FFFF, 0};
      vecs[5] = '{1'b0, 17'h103FC, 32'h0, 1};
      foreach (vecs[i]) applyStimulus(vecs[i]);
      doRead(17'h10010, 0, d2, r2);
      checkOutput("table_a5_data", d2, 32'hA5A5_A5A5);

      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
